ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have no parameters; widths fixed at 16-bit address, 16-bit data, 2 requesters (port 0, port 1).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  2  req[i]: requester i wants one RAM access this cycle.
REQ-005 we  in  2  we[i]: 1 = write, 0 = read; valid while req[i].
REQ-006 lock  in  2  lock[i]: granted requester i keeps ownership on following cycles.
REQ-007 addr  in  32  addr[16i+15:16i]: requester i address.
REQ-008 wdata  in  32  wdata[16i+15:16i]: requester i write data.
REQ-009 gnt  out  2  one-hot-or-zero; gnt[i] = access of requester i issued this cycle.
REQ-010 rvalid  out  2  rvalid[i]: rdata holds requester i read result this cycle.
REQ-011 rdata  out  16  read data, shared by both requesters, qualified by rvalid.
REQ-012 ram_address  out  16  to RAM address.
REQ-013 ram_data_in  out  16  to RAM data_in.
REQ-014 ram_control  out  2  to RAM control_signal; [1] chip select, [0] write enable.
REQ-015 ram_data_out  in  16  from RAM data_out_port; valid one cycle after a read is issued.

Function
REQ-016 gnt SHALL be combinational from req and registered state: an access is granted and presented to the RAM in the same cycle as req; a requester holds req/we/addr/wdata until it sees gnt.
REQ-017 At most one gnt bit SHALL be set per cycle; gnt = 00 when req = 00.
REQ-018 ram_address/ram_data_in SHALL mux the granted port's addr/wdata; ram_control = {1, we[i]} when gnt[i], else 00 (address/data don't-care).
REQ-019 Read latency SHALL be 1 cycle: a read granted in cycle N gives rvalid[i] = 1 in cycle N+1 with rdata = ram_data_out; writes produce no rvalid.
REQ-020 rvalid SHALL be a registered copy of (gnt & ~we); rdata SHALL pass ram_data_out through combinationally.
REQ-021 Back-to-back accesses SHALL be sustained: one grant per cycle, reads from both ports interleavable with no bubble.
REQ-022 FSM states: ARB (no owner) and LOCKED (owner = p).
REQ-023 ARB -> LOCKED(p): at a clock edge where gnt[p] & lock[p].
REQ-024 LOCKED(p): only port p may be granted; gnt[p] = req[p]; the other port waits regardless of priority.
REQ-025 LOCKED(p) -> ARB: at a clock edge where lock[p] = 0, or req[p] = 0 (lock without req releases).
REQ-026 lock[i] from a non-granted port in ARB SHALL be ignored.
REQ-027 A priority pointer SHALL record the last granted port; updated on every grant, including grants in LOCKED.

Reset
REQ-028 With reset = 1 at a rising edge: FSM -> ARB, pointer -> port 1 (port 0 has priority first), rvalid -> 00.
REQ-029 While reset = 1, gnt = 00 and ram_control = 00 regardless of req.
REQ-030 Reset mid-operation SHALL drop any pending read response (no rvalid the cycle after reset deasserts) and release any lock.

Configuration
REQ-031 Macro RAM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests in ARB, the port not granted most recently wins.
REQ-032 RAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins in ARB; pointer still maintained but unused; lock behaviour unchanged.

Verification
REQ-033 Reset, then req=01, we=00, addr0=0x0010 -> same cycle gnt=01, ram_control=10, ram_address=0x0010; next cycle rvalid=01, rdata=0x00FF (image pixel preload).
REQ-034 RR: req=11 held, both reads, 4 cycles -> gnt sequence 01,10,01,10; rvalid 01,10,01,10 one cycle delayed; fixed priority build -> gnt 01 all 4 cycles.
REQ-035 Port 1 write 0x1234 to 0x0004 (gnt=10, ram_control=11, no rvalid next cycle), then port 0 reads 0x0004 -> rvalid=01, rdata=0x1234.
REQ-036 Lock: port 1 granted with lock=10 for 3 cycles while req0=1 -> gnt=10 for 3 cycles; lock drops -> next cycle gnt=01.
REQ-037 Reset asserted in the cycle after a port-0 read grant -> rvalid=00, gnt=00, ram_control=00; after release, req=11 -> gnt=01.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port single-RAM arbiter with lock support and one-cycle read return.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (port 0 wins).
module ram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [1:0]  lock,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [15:0] rdata,
  output logic [15:0] ram_address,
  output logic [15:0] ram_data_in,
  output logic [1:0]  ram_control,
  input  logic [15:0] ram_data_out
);

  typedef enum logic {ARB, LOCKED} state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       ptr_q, ptr_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic       gnt_port;

  // Grant selection, lock tracking and priority pointer update
  always_comb begin
    gnt      = 2'b00;
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    rvalid_d = 2'b00;
    gnt_port = 1'b0;

    if (!reset) begin
      if (state_q == LOCKED) begin
        gnt = owner_q ? {req[1], 1'b0} : {1'b0, req[0]};
      end else if (req == 2'b11) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        gnt = ptr_q ? 2'b01 : 2'b10;
`else
        gnt = 2'b01;
`endif
      end else begin
        gnt = req;
      end
    end

    gnt_port = gnt[1];
    rvalid_d = gnt & ~we;
    if (|gnt) ptr_d = gnt_port;

    case (state_q)
      ARB: begin
        if ((|gnt) && lock[gnt_port]) begin
          state_d = LOCKED;
          owner_d = gnt_port;
        end
      end
      LOCKED: begin
        // Dropping either lock or req of the owner releases ownership
        if (!lock[owner_q] || !req[owner_q]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b1;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
    end
  end

  // A read response in flight when reset arrives is suppressed immediately
  assign rvalid      = rvalid_q & {2{~reset}};
  assign rdata       = ram_data_out;
  assign ram_address = gnt[1] ? addr[31:16]  : addr[15:0];
  assign ram_data_in = gnt[1] ? wdata[31:16] : wdata[15:0];
  assign ram_control = {|gnt, |(gnt & we)};

endmodule
